// File: rtl/inj_src_feeder_pkg.sv
// Shared types and constants for the injector source feeder.
package inj_feeder_pkg;

    localparam int FEEDER_FLIT_W = 32;
    localparam int FEEDER_CNT_W  = 32;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        SIZE    = 2'd1,
        PAYLOAD = 2'd2
    } feeder_state_t;

    // True when a size flit announces more payload than the injector accepts.
    function automatic logic size_exceeds(
        input logic [FEEDER_FLIT_W-1:0] n,
        input logic [FEEDER_FLIT_W-1:0] max_n
    );
        return (n > max_n);
    endfunction

endpackage

// File: rtl/inj_src_feeder_if.sv
// Host-side push handshake and injector-side credit handshake of the feeder.
interface inj_src_feeder_if;
    import inj_feeder_pkg::*;

    logic                     host_valid_i;
    logic                     host_ready_o;
    logic [FEEDER_FLIT_W-1:0] host_data_i;
    logic                     src_rx_o;
    logic                     src_credit_i;
    logic [FEEDER_FLIT_W-1:0] src_data_o;

    modport master (
        output host_valid_i, host_data_i, src_credit_i,
        input  host_ready_o, src_rx_o, src_data_o
    );

    modport slave (
        input  host_valid_i, host_data_i, src_credit_i,
        output host_ready_o, src_rx_o, src_data_o
    );

endinterface

// File: rtl/inj_src_feeder_fifo.sv
// feeder_fifo: power-of-two circular buffer; head reads as zero while empty.
module feeder_fifo
    import inj_feeder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [FEEDER_FLIT_W-1:0] wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [FEEDER_FLIT_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FEEDER_FLIT_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]            wr_ptr_r;
    logic [AW-1:0]            rd_ptr_r;
    logic [CW-1:0]            count_r;
    logic                     push_s;
    logic                     pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == CW'(0));
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign head   = empty ? {FEEDER_FLIT_W{1'b0}} : mem_r[rd_ptr_r];

    // Storage array; contents are only observable through head while non-empty.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; the occupancy counter separates full from empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/inj_src_feeder.sv
// inj_src_feeder: buffers host words and frames them as header/size/payload packets
// toward a credit-driven injector. Define INJ_SRC_FEEDER_STATS_EN for packet/flit counters.
module inj_src_feeder
    import inj_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH       = 8,
    parameter int MAX_PAYLOAD_SIZE = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    inj_src_feeder_if.slave         bus,
    output logic                    busy_o,
    output logic                    size_err_o,
    output logic [FEEDER_CNT_W-1:0] pkt_count_o,
    output logic [FEEDER_CNT_W-1:0] flit_count_o
);

    logic                     full_s;
    logic                     empty_s;
    logic [FEEDER_FLIT_W-1:0] head_s;
    logic                     xfer_s;

    feeder_state_t            state_r;
    logic [FEEDER_CNT_W-1:0]  remaining_r;
    logic                     size_err_r;

    feeder_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (bus.host_valid_i),
        .wdata (bus.host_data_i),
        .pop   (bus.src_credit_i),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    assign xfer_s           = ~empty_s & bus.src_credit_i;
    assign bus.host_ready_o = ~full_s;
    assign bus.src_rx_o     = ~empty_s;
    assign bus.src_data_o   = head_s;
    assign busy_o           = (state_r != HEADER) | ~empty_s;
    assign size_err_o       = size_err_r;

    // Framing FSM: advances only on transfers; the size flit loads the payload counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= HEADER;
            remaining_r <= {FEEDER_CNT_W{1'b0}};
            size_err_r  <= 1'b0;
        end else if (xfer_s) begin
            case (state_r)
                HEADER: begin
                    state_r <= SIZE;
                end
                SIZE: begin
                    if (size_exceeds(head_s, FEEDER_FLIT_W'(MAX_PAYLOAD_SIZE))) begin
                        size_err_r <= 1'b1;
                    end
                    remaining_r <= head_s;
                    state_r     <= (head_s == {FEEDER_FLIT_W{1'b0}}) ? HEADER : PAYLOAD;
                end
                PAYLOAD: begin
                    remaining_r <= remaining_r - FEEDER_CNT_W'(1);
                    if (remaining_r == FEEDER_CNT_W'(1)) begin
                        state_r <= HEADER;
                    end
                end
                default: begin
                    state_r     <= HEADER;
                    remaining_r <= {FEEDER_CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef INJ_SRC_FEEDER_STATS_EN
    logic                    pkt_done_s;
    logic [FEEDER_CNT_W-1:0] pkt_cnt_r;
    logic [FEEDER_CNT_W-1:0] flit_cnt_r;

    // A packet completes on the transfer that returns the FSM to HEADER.
    always_comb begin
        pkt_done_s = 1'b0;
        case (state_r)
            SIZE:    pkt_done_s = xfer_s & (head_s == {FEEDER_FLIT_W{1'b0}});
            PAYLOAD: pkt_done_s = xfer_s & (remaining_r == FEEDER_CNT_W'(1));
            default: pkt_done_s = 1'b0;
        endcase
    end

    // Free-running statistics; both wrap at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_cnt_r  <= {FEEDER_CNT_W{1'b0}};
            flit_cnt_r <= {FEEDER_CNT_W{1'b0}};
        end else begin
            if (xfer_s) begin
                flit_cnt_r <= flit_cnt_r + FEEDER_CNT_W'(1);
            end
            if (pkt_done_s) begin
                pkt_cnt_r <= pkt_cnt_r + FEEDER_CNT_W'(1);
            end
        end
    end

    assign pkt_count_o  = pkt_cnt_r;
    assign flit_count_o = flit_cnt_r;
`else
    assign pkt_count_o  = {FEEDER_CNT_W{1'b0}};
    assign flit_count_o = {FEEDER_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_inj_src_feeder.sv
// Self-checking bench for inj_src_feeder against a queue-based packet model.
module tb_inj_src_feeder;

    localparam int DEPTH = 8;
    localparam int MAXP  = 32;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        size_err;
    logic [31:0] pkt_count;
    logic [31:0] flit_count;

    inj_src_feeder_if bus();

    inj_src_feeder #(
        .FIFO_DEPTH       (DEPTH),
        .MAX_PAYLOAD_SIZE (MAXP)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .busy_o       (busy),
        .size_err_o   (size_err),
        .pkt_count_o  (pkt_count),
        .flit_count_o (flit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_asserts = 0;
    int          n_fail    = 0;
    int          mode      = 1;    // 0: credit low, 1: credit high, 2: random credit and valid gaps
    logic [31:0] hostq[$];         // words the host still wants to send
    logic [31:0] mq[$];            // words held by the feeder
    logic [31:0] log_q[$];         // words delivered to the injector since reset

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat(input int unsigned v);
`ifdef INJ_SRC_FEEDER_STATS_EN
        return 32'(v);
`else
        return 32'(v) & 32'h0;
`endif
    endfunction

    // Split the delivered stream into packets: header, size n, n payload words.
    function automatic void parse(output int unsigned pk, output bit err, output bit open);
        longint i, n, sz;
        pk = 0; err = 1'b0; open = 1'b0; i = 0;
        sz = longint'(log_q.size());
        while (i < sz) begin
            if (i + 1 >= sz) begin
                open = 1'b1;
                break;
            end
            n = longint'({32'h0, log_q[i+1]});
            if (n > MAXP) err = 1'b1;
            if (i + 2 + n <= sz) pk++;
            else open = 1'b1;
            i = i + 2 + n;
        end
    endfunction

    task automatic cycle();
        bit v, c, push, pop, err, open;
        int unsigned pk;
        if (mode == 2) v = (hostq.size() > 0) && ($urandom_range(0, 3) != 0);
        else           v = (hostq.size() > 0);
        if (mode == 0)      c = 1'b0;
        else if (mode == 1) c = 1'b1;
        else                c = 1'($urandom_range(0, 1));
        bus.host_valid_i = v;
        bus.host_data_i  = v ? hostq[0] : 32'h0;
        bus.src_credit_i = c;
        @(negedge clk);
        parse(pk, err, open);
        chk("host_ready", 32'(bus.host_ready_o), 32'(mq.size() < DEPTH));
        chk("src_rx", 32'(bus.src_rx_o), 32'(mq.size() > 0));
        chk("src_data", bus.src_data_o, (mq.size() > 0) ? mq[0] : 32'h0);
        chk("busy", 32'(busy), 32'(open || (mq.size() > 0)));
        chk("size_err", 32'(size_err), 32'(err));
        chk("pkt_count", pkt_count, stat(pk));
        chk("flit_count", flit_count, stat(log_q.size()));
        push = v && (mq.size() < DEPTH);
        pop  = (mq.size() > 0) && c;
        @(posedge clk);
        if (pop)  log_q.push_back(mq.pop_front());
        if (push) mq.push_back(hostq.pop_front());
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        int guard = 0;
        while ((hostq.size() > 0 || mq.size() > 0) && guard < 5000) begin
            cycle();
            guard++;
        end
        chk("drain_timeout", 32'(hostq.size() + mq.size()), 32'h0);
        cycle();
    endtask

    task automatic chk_reset();
        chk("rst_host_ready", 32'(bus.host_ready_o), 32'h1);
        chk("rst_src_rx", 32'(bus.src_rx_o), 32'h0);
        chk("rst_src_data", bus.src_data_o, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_size_err", 32'(size_err), 32'h0);
        chk("rst_pkt_count", pkt_count, 32'h0);
        chk("rst_flit_count", flit_count, 32'h0);
    endtask

    task automatic add_pkt(input logic [31:0] hdr, input int unsigned n, input logic [31:0] base);
        hostq.push_back(hdr);
        hostq.push_back(32'(n));
        for (int k = 0; k < int'(n); k++) hostq.push_back(base + 32'(k));
    endtask

    initial begin
        rst = 1'b1;
        bus.host_valid_i = 1'b0;
        bus.host_data_i  = 32'h0;
        bus.src_credit_i = 1'b0;
        #2;
        chk_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic packet with credit always available.
        mode = 1;
        hostq = '{32'h0000_0101, 32'h2, 32'hA, 32'hB};
        drain();
        chk("basic_pkt", pkt_count, stat(1));
        chk("basic_flit", flit_count, stat(4));
        chk("basic_busy", 32'(busy), 32'h0);

        // Fill with credit withheld; head must stay put while full.
        mode = 0;
        add_pkt(32'h0000_0202, 6, 32'h100);
        run(10);
        chk("full_ready", 32'(bus.host_ready_o), 32'h0);
        chk("hold_head", bus.src_data_o, 32'h0000_0202);
        mode = 1;
        drain();
        chk("fill_pkt", pkt_count, stat(2));

        // Zero-length packet followed by a one-flit payload.
        add_pkt(32'h0000_0303, 0, 32'h0);
        add_pkt(32'h0000_0304, 1, 32'h5);
        drain();
        chk("zero_len_pkt", pkt_count, stat(4));
        chk("zero_len_err", 32'(size_err), 32'h0);
        chk("zero_len_busy", 32'(busy), 32'h0);

        // Random legal packets with random credit and valid gaps.
        mode = 2;
        for (int p = 0; p < 8; p++) add_pkt(32'hA000_0000 | 32'(p), $urandom_range(0, MAXP), $urandom());
        drain();
        chk("legal_err", 32'(size_err), 32'h0);

        // Oversize packet is forwarded in full and leaves a sticky error.
        add_pkt(32'h0000_0404, 33, 32'h200);
        drain();
        chk("oversize_err", 32'(size_err), 32'h1);
        for (int p = 0; p < 8; p++) add_pkt(32'hB000_0000 | 32'(p), $urandom_range(0, 40), $urandom());
        drain();
        chk("sticky_err", 32'(size_err), 32'h1);

        // Reset while in payload with three words buffered.
        mode = 1;
        add_pkt(32'h0000_0505, 10, 32'h300);
        repeat (7) void'(hostq.pop_back());
        drain();
        mode = 0;
        hostq = '{32'h302, 32'h303, 32'h304};
        run(3);
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_src_rx", 32'(bus.src_rx_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset();
        hostq.delete();
        mq.delete();
        log_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mode = 1;
        add_pkt(32'h0000_0606, 1, 32'h7);
        drain();
        chk("post_rst_pkt", pkt_count, stat(1));
        chk("post_rst_flit", flit_count, stat(3));
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_err", 32'(size_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
